// File: rtl/cache_mem_responder_if.sv
// Line-request bus between the cache lower side (master) and the backing-memory responder (slave).
interface cache_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  write_ack;

    modport master (
        output req_valid, req_write, req_addr, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_last, write_ack
    );

    modport slave (
        input  req_valid, req_write, req_addr, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_data, rd_last, write_ack
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Backing-memory responder: fixed-latency line refills and write-back absorption into a word array.
// Optional macro CACHE_MEM_RESP_CRITICAL_WORD_FIRST_EN starts refills at the requested word.
module cache_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int MEM_WORDS  = 4096,
    parameter int LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_mem_responder_if.slave bus
);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int LINE_W = IDX_W - OFF_W;
    localparam int LAT_W  = $clog2(LATENCY + 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(LATENCY - 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT} state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_wr_ready;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_last;
    logic                  r_write_ack;
    logic [OFF_W-1:0]      r_beat;
    logic [LAT_W-1:0]      r_lat;
    logic [LINE_W-1:0]     r_line;
    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic [LINE_W-1:0]     w_req_line;
    logic [OFF_W-1:0]      w_rd_off;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_accept;
    logic                  w_wr_fire;
    logic                  w_emit;

    assign w_req_line = bus.req_addr[2+OFF_W +: LINE_W];
    assign w_accept   = (r_state == IDLE) && bus.req_valid;
    // wr_ready lags the state by one cycle, so the state gates the beat accept as well.
    assign w_wr_fire  = (r_state == WR_BURST) && bus.wr_valid && r_wr_ready;
    assign w_emit     = ((r_state == RD_WAIT) && (r_lat == '0)) ||
                        ((r_state == RD_BURST) && !r_rd_last);

`ifdef CACHE_MEM_RESP_CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0] r_woff;
    assign w_rd_off = r_woff + r_beat;
    always_ff @(posedge clk) begin
        if (w_accept) r_woff <= bus.req_addr[2 +: OFF_W];
    end
`else
    assign w_rd_off = r_beat;
`endif

    assign w_rd_idx = {r_line, w_rd_off};
    assign w_wr_idx = {r_line, r_beat};

    // Array and latched line address are data: never reset, so a reset keeps committed beats.
    always_ff @(posedge clk) begin
        if (w_accept)  r_line            <= w_req_line;
        if (w_wr_fire) r_mem[w_wr_idx]   <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_wr_ready  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_last   <= 1'b0;
            r_write_ack <= 1'b0;
            r_beat      <= '0;
            r_lat       <= '0;
        end else begin
            r_wr_ready <= (r_state == WR_BURST);
            if (w_emit) begin
                r_state    <= RD_BURST;
                r_rd_valid <= 1'b1;
                r_rd_data  <= r_mem[w_rd_idx];
                r_rd_last  <= (r_beat == LAST_BEAT);
                r_beat     <= r_beat + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_req_ready <= 1'b0;
                        r_beat      <= '0;
                        r_lat       <= LAT_INIT;
                        r_state     <= bus.req_write ? WR_BURST : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (r_lat != '0) r_lat <= r_lat - 1'b1;
                end
                RD_BURST: begin
                    if (r_rd_last) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                        r_rd_valid  <= 1'b0;
                        r_rd_data   <= '0;
                        r_rd_last   <= 1'b0;
                    end
                end
                WR_BURST: begin
                    if (w_wr_fire) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == LAST_BEAT) begin
                            r_state <= WR_WAIT;
                            r_lat   <= LAT_INIT;
                        end
                    end
                end
                WR_WAIT: begin
                    if (r_write_ack) begin
                        r_write_ack <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else if (r_lat == '0) begin
                        r_write_ack <= 1'b1;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.wr_ready  = r_wr_ready;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_last   = r_rd_last;
    assign bus.write_ack = r_write_ack;
endmodule
